// File: rtl/clock_digit_counter.sv
// Six-digit BCD time-of-day counter with one-second prescaler and per-digit set strobes.
// Defining CLOCK_12H_EN selects a 12-hour clock (12,01..11) with a PM flag; default is 24-hour.
module clock_digit_counter #(
  parameter int CLKS_PER_SECOND = 100000000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Run_Enable,
  input  logic [5:0]  i_Digit_Inc,
  input  logic [5:0]  i_Digit_Dec,
  output logic [23:0] o_Time_BCD,
  output logic        o_Day_Tick,
  output logic        o_PM
);

  localparam int PRESC_W = (CLKS_PER_SECOND > 1) ? $clog2(CLKS_PER_SECOND) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLKS_PER_SECOND - 1);

`ifdef CLOCK_12H_EN
  localparam logic [3:0] HR_TENS_RESET = 4'd1;
  localparam logic [3:0] HR_ONES_RESET = 4'd2;
`else
  localparam logic [3:0] HR_TENS_RESET = 4'd0;
  localparam logic [3:0] HR_ONES_RESET = 4'd0;
`endif

  typedef enum logic [2:0] {
    SEL_SEC_ONES = 3'd0,
    SEL_SEC_TENS = 3'd1,
    SEL_MIN_ONES = 3'd2,
    SEL_MIN_TENS = 3'd3,
    SEL_HR_ONES  = 3'd4,
    SEL_HR_TENS  = 3'd5,
    SEL_NONE     = 3'd6
  } digit_sel_e;

  logic [PRESC_W-1:0] presc_q;
  logic               pend_q;
  logic [3:0]         sec_ones_q, sec_tens_q, min_ones_q, min_tens_q, hr_ones_q, hr_tens_q;
  logic [3:0]         sec_ones_d, sec_tens_d, min_ones_d, min_tens_d, hr_ones_d, hr_tens_d;
  logic               day_d, pm_d, pm_q;

  logic               sec_tick, strobe_any, apply_tick, pend_d, hour_carry;
  digit_sel_e         sel;
  logic               sel_up, sel_conflict;

  // Single-digit step with wrap inside [lo, hi]; never carries.
  function automatic logic [3:0] wrap_step(input logic [3:0] d, input logic [3:0] lo,
                                           input logic [3:0] hi, input logic up);
    if (up) return (d >= hi) ? lo : d + 4'd1;
    else    return (d <= lo) ? hi : d - 4'd1;
  endfunction

  assign sec_tick   = i_Run_Enable && (presc_q == PRESC_MAX);
  assign strobe_any = |(i_Digit_Inc | i_Digit_Dec);
  // A strobe wins the cycle; a tick seen alongside it waits one deep until a strobe-free cycle.
  assign apply_tick = i_Run_Enable && (sec_tick || pend_q) && !strobe_any;
  assign pend_d     = i_Run_Enable && (sec_tick || pend_q) && strobe_any;

  // Lowest asserted strobe index selects the digit.
  always_comb begin
    sel          = SEL_NONE;
    sel_up       = 1'b0;
    sel_conflict = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (i_Digit_Inc[i] || i_Digit_Dec[i]) begin
        sel          = digit_sel_e'(3'(i));
        sel_up       = i_Digit_Inc[i];
        sel_conflict = i_Digit_Inc[i] && i_Digit_Dec[i];
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    hr_ones_d  = hr_ones_q;
    hr_tens_d  = hr_tens_q;
    day_d      = 1'b0;
    pm_d       = pm_q;
    hour_carry = 1'b0;

    if (apply_tick) begin
      if (sec_ones_q != 4'd9) sec_ones_d = sec_ones_q + 4'd1;
      else begin
        sec_ones_d = 4'd0;
        if (sec_tens_q != 4'd5) sec_tens_d = sec_tens_q + 4'd1;
        else begin
          sec_tens_d = 4'd0;
          if (min_ones_q != 4'd9) min_ones_d = min_ones_q + 4'd1;
          else begin
            min_ones_d = 4'd0;
            if (min_tens_q != 4'd5) min_tens_d = min_tens_q + 4'd1;
            else begin
              min_tens_d = 4'd0;
              hour_carry = 1'b1;
            end
          end
        end
      end

      if (hour_carry) begin
`ifdef CLOCK_12H_EN
        if (hr_tens_q == 4'd1 && hr_ones_q == 4'd1) begin
          hr_ones_d = 4'd2;
          pm_d      = !pm_q;
          day_d     = pm_q;
        end else if (hr_tens_q == 4'd1 && hr_ones_q == 4'd2) begin
          hr_tens_d = 4'd0;
          hr_ones_d = 4'd1;
        end else if (hr_ones_q == 4'd9) begin
          hr_tens_d = hr_tens_q + 4'd1;
          hr_ones_d = 4'd0;
        end else begin
          hr_ones_d = hr_ones_q + 4'd1;
        end
`else
        if (hr_tens_q == 4'd2 && hr_ones_q == 4'd3) begin
          hr_tens_d = 4'd0;
          hr_ones_d = 4'd0;
          day_d     = 1'b1;
        end else if (hr_ones_q == 4'd9) begin
          hr_tens_d = hr_tens_q + 4'd1;
          hr_ones_d = 4'd0;
        end else begin
          hr_ones_d = hr_ones_q + 4'd1;
        end
`endif
      end
    end else if (strobe_any && !sel_conflict) begin
      case (sel)
        SEL_SEC_ONES: sec_ones_d = wrap_step(sec_ones_q, 4'd0, 4'd9, sel_up);
        SEL_SEC_TENS: sec_tens_d = wrap_step(sec_tens_q, 4'd0, 4'd5, sel_up);
        SEL_MIN_ONES: min_ones_d = wrap_step(min_ones_q, 4'd0, 4'd9, sel_up);
        SEL_MIN_TENS: min_tens_d = wrap_step(min_tens_q, 4'd0, 4'd5, sel_up);
`ifdef CLOCK_12H_EN
        SEL_HR_ONES: begin
          if (hr_tens_q == 4'd0) hr_ones_d = wrap_step(hr_ones_q, 4'd1, 4'd9, sel_up);
          else                   hr_ones_d = wrap_step(hr_ones_q, 4'd0, 4'd2, sel_up);
        end
        SEL_HR_TENS: begin
          hr_tens_d = wrap_step(hr_tens_q, 4'd0, 4'd1, sel_up);
          if (hr_tens_d == 4'd1 && hr_ones_q > 4'd2) hr_ones_d = 4'd2;
          if (hr_tens_d == 4'd0 && hr_ones_q == 4'd0) hr_ones_d = 4'd1;
        end
`else
        SEL_HR_ONES: begin
          hr_ones_d = wrap_step(hr_ones_q, 4'd0, (hr_tens_q == 4'd2) ? 4'd3 : 4'd9, sel_up);
        end
        SEL_HR_TENS: begin
          hr_tens_d = wrap_step(hr_tens_q, 4'd0, 4'd2, sel_up);
          if (hr_tens_d == 4'd2 && hr_ones_q > 4'd3) hr_ones_d = 4'd3;
        end
`endif
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      presc_q    <= '0;
      pend_q     <= 1'b0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      hr_ones_q  <= HR_ONES_RESET;
      hr_tens_q  <= HR_TENS_RESET;
      pm_q       <= 1'b0;
      o_Day_Tick <= 1'b0;
    end else begin
      if (!i_Run_Enable || presc_q == PRESC_MAX) presc_q <= '0;
      else                                        presc_q <= presc_q + 1'b1;
      pend_q     <= pend_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      hr_ones_q  <= hr_ones_d;
      hr_tens_q  <= hr_tens_d;
      pm_q       <= pm_d;
      o_Day_Tick <= day_d;
    end
  end

  assign o_Time_BCD = {hr_tens_q, hr_ones_q, min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
  assign o_PM       = pm_q;

endmodule

// File: tb/tb_clock_digit_counter.sv
// Randomized bench for clock_digit_counter against a seconds/minutes/hours reference model.
// Builds for either hour mode; CLOCK_12H_EN selects the 12-hour expectations.
module tb_clock_digit_counter;

  localparam int CPS = 4;
`ifdef CLOCK_12H_EN
  localparam bit          IS_12H    = 1'b1;
  localparam logic [23:0] RESET_BCD = 24'h120000;
`else
  localparam bit          IS_12H    = 1'b0;
  localparam logic [23:0] RESET_BCD = 24'h000000;
`endif

  logic        clk = 1'b0;
  logic        rst, run;
  logic [5:0]  inc, dec;
  logic [23:0] time_bcd;
  logic        day_tick, pm;

  always #5 clk = ~clk;

  clock_digit_counter #(.CLKS_PER_SECOND(CPS)) dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Run_Enable(run),
    .i_Digit_Inc (inc),
    .i_Digit_Dec (dec),
    .o_Time_BCD  (time_bcd),
    .o_Day_Tick  (day_tick),
    .o_PM        (pm)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: time held as plain hour/minute/second integers.
  int m_h = 0, m_m = 0, m_s = 0, m_presc = 0;
  bit m_pm = 0, m_day = 0, m_pend = 0;

  function automatic int wrap_n(input int v, input int lo, input int hi, input bit up);
    int n = hi - lo + 1;
    return ((v - lo + (up ? 1 : n - 1)) % n) + lo;
  endfunction

  function automatic logic [23:0] model_bcd();
    return {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10), 4'(m_s / 10), 4'(m_s % 10)};
  endfunction

  function automatic int model_digit(input int idx);
    case (idx)
      0: return m_s % 10;
      1: return m_s / 10;
      2: return m_m % 10;
      3: return m_m / 10;
      4: return m_h % 10;
      default: return m_h / 10;
    endcase
  endfunction

  task automatic model_advance();
    m_s++;
    if (m_s == 60) begin
      m_s = 0;
      m_m++;
      if (m_m == 60) begin
        m_m = 0;
        if (IS_12H) begin
          if (m_h == 11) begin
            m_h   = 12;
            m_day = m_pm;
            m_pm  = !m_pm;
          end else begin
            m_h = (m_h == 12) ? 1 : m_h + 1;
          end
        end else begin
          m_h = (m_h + 1) % 24;
          if (m_h == 0) m_day = 1;
        end
      end
    end
  endtask

  task automatic model_strobe(input int idx, input bit up);
    int so = m_s % 10, st = m_s / 10, mo = m_m % 10, mt = m_m / 10;
    int ho = m_h % 10, ht = m_h / 10;
    case (idx)
      0: so = wrap_n(so, 0, 9, up);
      1: st = wrap_n(st, 0, 5, up);
      2: mo = wrap_n(mo, 0, 9, up);
      3: mt = wrap_n(mt, 0, 5, up);
      4: begin
        if (IS_12H) ho = (ht == 0) ? wrap_n(ho, 1, 9, up) : wrap_n(ho, 0, 2, up);
        else        ho = wrap_n(ho, 0, (ht == 2) ? 3 : 9, up);
      end
      default: begin
        if (IS_12H) begin
          ht = wrap_n(ht, 0, 1, up);
          if (ht == 1 && ho > 2) ho = 2;
          if (ht == 0 && ho == 0) ho = 1;
        end else begin
          ht = wrap_n(ht, 0, 2, up);
          if (ht == 2 && ho > 3) ho = 3;
        end
      end
    endcase
    m_s = st * 10 + so;
    m_m = mt * 10 + mo;
    m_h = ht * 10 + ho;
  endtask

  task automatic model_clock();
    bit tick;
    int low;
    if (rst) begin
      m_presc = 0; m_pend = 0; m_day = 0; m_pm = 0;
      m_h = IS_12H ? 12 : 0; m_m = 0; m_s = 0;
      return;
    end
    m_day   = 0;
    tick    = run && (m_presc == CPS - 1);
    m_presc = (run && m_presc != CPS - 1) ? m_presc + 1 : 0;
    if ((inc | dec) != 6'd0) begin
      low = 0;
      while (!(inc[low] || dec[low])) low++;
      if (!(inc[low] && dec[low])) model_strobe(low, inc[low]);
      m_pend = run && (tick || m_pend);
    end else begin
      if (run && (tick || m_pend)) model_advance();
      m_pend = 0;
    end
  endtask

  // One clock: model follows the edge, DUT compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check("time", 32'(time_bcd), 32'(model_bcd()));
    check("day_tick", 32'(day_tick), 32'(m_day));
    check("pm", 32'(pm), 32'(m_pm));
  endtask

  task automatic set_digit(input int idx, input int target);
    for (int k = 0; k < 12 && model_digit(idx) != target; k++) begin
      inc = 6'(1 << idx);
      step();
      inc = 6'd0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  bit          seen;
  logic [23:0] t_at;

  initial begin
    rst = 1'b1; run = 1'b0; inc = 6'd0; dec = 6'd0;

    do_reset();
    check("reset_time", 32'(time_bcd), 32'(RESET_BCD));
    check("reset_day_tick", 32'(day_tick), 32'd0);
    check("reset_pm", 32'(pm), 32'd0);

    // Free run for 40 cycles gives ten seconds.
    run  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (day_tick) seen = 1'b1;
    end
    check("run40_time", 32'(time_bcd), 32'(RESET_BCD | 24'h000010));
    check("run40_no_day_tick", 32'(seen), 32'd0);
    run = 1'b0;

`ifdef CLOCK_12H_EN
    do_reset();
    set_digit(4, 1); set_digit(3, 5); set_digit(2, 9); set_digit(1, 5); set_digit(0, 9);
    check("preload_11_59_59", 32'(time_bcd), 32'h115959);
    run  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (day_tick) seen = 1'b1;
      if (time_bcd == 24'h120000) break;
    end
    check("noon_time", 32'(time_bcd), 32'h120000);
    check("noon_pm", 32'(pm), 32'd1);
    check("noon_no_day_tick", 32'(seen), 32'd0);
    run = 1'b0;
`else
    set_digit(5, 2); set_digit(4, 3); set_digit(3, 5); set_digit(2, 9); set_digit(1, 5); set_digit(0, 9);
    check("preload_23_59_59", 32'(time_bcd), 32'h235959);
    run  = 1'b1;
    seen = 1'b0;
    t_at = 24'hFFFFFF;
    for (int k = 0; k < 8; k++) begin
      step();
      if (day_tick) begin
        seen = 1'b1;
        t_at = time_bcd;
        break;
      end
    end
    check("midnight_day_tick_seen", 32'(seen), 32'd1);
    check("midnight_time", 32'(t_at), 32'h000000);
    step();
    check("day_tick_one_cycle", 32'(day_tick), 32'd0);
    run = 1'b0;

    set_digit(5, 1); set_digit(4, 9); set_digit(3, 0); set_digit(2, 0); set_digit(1, 0); set_digit(0, 0);
    check("preload_19", 32'(time_bcd), 32'h190000);
    inc = 6'b100000; step();
    check("hr_tens_clamp", 32'(time_bcd), 32'h230000);
    step();
    check("hr_tens_wrap", 32'(time_bcd), 32'h030000);
    inc = 6'd0;
`endif

    // Seconds-tens decrement wraps without borrowing.
    do_reset();
    dec = 6'b000010; step(); dec = 6'd0;
    check("sec_tens_dec_wrap", 32'(time_bcd), 32'(RESET_BCD | 24'h000050));

    // Strobe in the tick cycle: digit first, held tick next cycle.
    do_reset();
    run = 1'b1;
    step(); step(); step();
    inc = 6'b000100; step(); inc = 6'd0;
    check("strobe_in_tick_cycle", 32'(time_bcd), 32'(RESET_BCD | 24'h000100));
    step();
    check("held_tick_applied", 32'(time_bcd), 32'(RESET_BCD | 24'h000101));
    inc = 6'b000001; dec = 6'b000001; step(); inc = 6'd0; dec = 6'd0;
    check("inc_dec_conflict", 32'(time_bcd), 32'(RESET_BCD | 24'h000101));

    // Held tick is dropped when run falls.
    do_reset();
    step(); step(); step();
    inc = 6'b000001; step(); inc = 6'd0;
    run = 1'b0; step(); step();
    check("pending_discard", 32'(time_bcd), 32'(RESET_BCD | 24'h000001));

    // Reset beats strobes and a running tick.
    run = 1'b1; step(); step(); step();
    rst = 1'b1; inc = 6'h3f; step(); rst = 1'b0; inc = 6'd0;
    check("reset_priority", 32'(time_bcd), 32'(RESET_BCD));

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) run = !run;
      inc = 6'd0;
      dec = 6'd0;
      case ($urandom_range(0, 7))
        0: inc = 6'(1 << $urandom_range(0, 5));
        1: dec = 6'(1 << $urandom_range(0, 5));
        2: begin inc = 6'($urandom); dec = 6'($urandom); end
        default: ;
      endcase
      step();
    end
    rst = 1'b0; inc = 6'd0; dec = 6'd0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
